music_sequencer: RTL and testbench
==================================

Name: music_sequencer

Overview:
- Parametrised melody player for the game audio path; successor to the fixed-tone square-wave generators.
- Plays a programmable sequence of notes, each entry carrying semitone, octave, rest flag and duration in beats, from an internal melody RAM.
- Provides start/stop control, optional looping and a completion pulse, so game-state logic can trigger victory or fault jingles and wait for them to finish.
- Output drives the speaker pin directly as a 50% duty square wave.

Parameters:
- DEPTH, 16, number of melody RAM entries; must be a power of 2, minimum 2.
- ADDR_W, 4, equals log2(DEPTH).
- TEMPO_CYC, 6250000, clock cycles per beat; minimum 2.
- TEMPO_W, 23, width of the beat prescaler; must hold TEMPO_CYC-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  level-sampled; when high in IDLE, playback begins at entry 0.
- stop  in  1  abort playback; has priority over start.
- loop_en  in  1  1 = restart at entry 0 on end of melody instead of finishing.
- wr_en  in  1  melody RAM write strobe.
- wr_addr  in  ADDR_W  RAM write address.
- wr_data  in  12  entry format: [11] rest, [10:8] octave, [7:4] note (0=A … 11=G#), [3:0] duration in beats; duration 0 = end marker.
- music_out  out  1  square-wave audio.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on normal, non-loop melody completion.
- note_idx  out  ADDR_W  index of the entry being fetched or played.

Behaviour:
- Reset, and any cycle with rst high: state IDLE, music_out=0, busy=0, done=0, note_idx=0, all counters 0. RAM contents are not cleared.
- RAM writes occur whenever wr_en is high, in any state.
- A write to the entry currently playing takes effect only on that entry's next fetch.
- FSM states: IDLE, FETCH, PLAY.
- IDLE -> FETCH when start=1 and stop=0. Sets note_idx=0.
- start is ignored while busy.
- FETCH lasts exactly 1 cycle (registered RAM read). The entry is evaluated in the following cycle:
  - duration=0, loop_en=1, note_idx!=0: note_idx=0, FETCH again.
  - duration=0, loop_en=1, note_idx=0: treated as end of melody, to avoid an infinite empty loop.
  - duration=0 otherwise: done=1 for one cycle, go to IDLE.
  - duration!=0: go to PLAY. Load beat count = duration, tempo prescaler = TEMPO_CYC-1, note prescaler = div-1, octave counter = 2^(7-octave)-1. music_out=0.
- Semitone divisor table (div), fixed: 512, 483, 456, 431, 406, 384, 362, 342, 323, 304, 287, 271 for note 0..11.
- Note codes 12..15 are treated as rest.
- Tone generation in PLAY:
  - Note prescaler counts down to 0, then reloads div-1.
  - On each prescaler expiry: if the octave counter is 0, reload it and toggle music_out; otherwise decrement it.
  - Resulting half-period = div × 2^(7-octave) cycles.
- Rest entries: music_out is held 0 for the full duration.
- Tempo in PLAY:
  - Tempo prescaler counts down each cycle.
  - At 0 it reloads TEMPO_CYC-1 and decrements the beat count.
  - When the beat count reaches 0: music_out=0, note_idx increments, go to FETCH.
  - Entry duration is exactly duration × TEMPO_CYC cycles in PLAY, plus 1 FETCH cycle per entry.
- End of RAM: an increment from DEPTH-1 is handled as end of melody without a fetch. With loop_en=1 it wraps to 0 and goes to FETCH; otherwise done pulses and the FSM returns to IDLE.
- stop=1 in any state: next cycle state=IDLE, music_out=0, busy=0, note_idx=0, no done pulse.
- Simultaneous start and stop: stop wins.
- loop_en is sampled only at end-of-melody decisions.
- done and a new start in the same cycle: start is accepted only on the next cycle, once in IDLE.

Test Plan:
- Reset: drive rst high mid-PLAY -> next cycle music_out=0, busy=0, done=0, note_idx=0.
- Tone pitch: TEMPO_CYC=20000; entry0 = octave 7, note 0, duration 1; entry1 = end -> music_out toggles every 512 cycles. Change entry0 to octave 6, note 11 -> toggles every 542 cycles.
- Sequencing: entries {oct7 A dur2, rest dur1, oct7 C dur1, end}, TEMPO_CYC=2000 -> note_idx holds each value for 4001, 2001 and 2001 cycles respectively. music_out is 0 throughout the rest. done pulses exactly once, busy falls with it.
- Loop and empty loop: same melody with loop_en=1 -> note_idx returns to 0 after entry 2 and done never pulses. All-end RAM with loop_en=1 -> done pulses 2 cycles after start.
- Full RAM: DEPTH=4, all entries dur1, no end marker, loop_en=0 -> plays indices 0..3, then done; no fetch beyond index 3.
- Stop and priority: stop asserted during a PLAY beat -> IDLE next cycle with no done. start and stop together in IDLE -> stays IDLE. start pulse while busy -> no restart.

Source files
------------

// File: rtl/music_sequencer.sv
// Melody player: steps through a small melody RAM and renders each entry as a
// 50% duty square wave (or silence for rests) for a whole number of beats.
module music_sequencer #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int TEMPO_CYC = 6250000,
  parameter int TEMPO_W   = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [11:0]       wr_data,
  output logic              music_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] note_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2
  } state_t;

  localparam logic [TEMPO_W-1:0] TEMPO_RELOAD = TEMPO_W'(TEMPO_CYC - 1);
  localparam logic [TEMPO_W-1:0] TEMPO_ONE    = TEMPO_W'(1);
  localparam logic [ADDR_W-1:0]  LAST_IDX     = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0]  IDX_ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]  IDX_ZERO     = '0;

  logic [11:0]        mem_q [DEPTH];
  logic [11:0]        rdData_q;

  state_t             state_q;
  logic               music_q;
  logic               busy_q;
  logic               done_q;
  logic [ADDR_W-1:0]  noteIdx_q;

  logic [3:0]         beat_q;
  logic [TEMPO_W-1:0] tempo_q;
  logic [8:0]         notePre_q;
  logic [8:0]         divReload_q;
  logic [6:0]         oct_q;
  logic [6:0]         octReload_q;
  logic               rest_q;

  logic [3:0]         entryDur;
  logic               entryRest;
  logic [8:0]         divLoad;
  logic [6:0]         octLoad;
  logic [ADDR_W-1:0]  nextIdx;

  assign entryDur  = rdData_q[3:0];
  assign entryRest = rdData_q[11] | (rdData_q[7:4] >= 4'd12);
  assign octLoad   = 7'((8'd1 << (3'd7 - rdData_q[10:8])) - 8'd1);
  assign nextIdx   = noteIdx_q + IDX_ONE;

  // Semitone lookup: prescaler reload value (divisor minus one) for the fetched note
  always_comb begin
    divLoad = 9'd511;
    case (rdData_q[7:4])
      4'd0:    divLoad = 9'd511;
      4'd1:    divLoad = 9'd482;
      4'd2:    divLoad = 9'd455;
      4'd3:    divLoad = 9'd430;
      4'd4:    divLoad = 9'd405;
      4'd5:    divLoad = 9'd383;
      4'd6:    divLoad = 9'd361;
      4'd7:    divLoad = 9'd341;
      4'd8:    divLoad = 9'd322;
      4'd9:    divLoad = 9'd303;
      4'd10:   divLoad = 9'd286;
      4'd11:   divLoad = 9'd270;
      default: divLoad = 9'd511;
    endcase
  end

  // Melody RAM write port; contents survive reset so jingles need loading only once
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Sequencer FSM: fetch entry, play it for its beats, advance or finish; the RAM read
  // is issued on the transition into FETCH so the entry is ready during that cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      music_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      noteIdx_q   <= '0;
      rdData_q    <= '0;
      beat_q      <= '0;
      tempo_q     <= '0;
      notePre_q   <= '0;
      divReload_q <= '0;
      oct_q       <= '0;
      octReload_q <= '0;
      rest_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        state_q   <= IDLE;
        music_q   <= 1'b0;
        busy_q    <= 1'b0;
        noteIdx_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q   <= FETCH;
              busy_q    <= 1'b1;
              noteIdx_q <= '0;
              rdData_q  <= mem_q[IDX_ZERO];
            end
          end

          FETCH: begin
            if (entryDur == 4'd0) begin
              if (loop_en && (noteIdx_q != IDX_ZERO)) begin
                state_q   <= FETCH;
                noteIdx_q <= '0;
                rdData_q  <= mem_q[IDX_ZERO];
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              state_q     <= PLAY;
              beat_q      <= entryDur;
              tempo_q     <= TEMPO_RELOAD;
              notePre_q   <= divLoad;
              divReload_q <= divLoad;
              oct_q       <= octLoad;
              octReload_q <= octLoad;
              rest_q      <= entryRest;
              music_q     <= 1'b0;
            end
          end

          PLAY: begin
            if (notePre_q == 9'd0) begin
              notePre_q <= divReload_q;
              if (oct_q == 7'd0) begin
                oct_q <= octReload_q;
                if (!rest_q) begin
                  music_q <= ~music_q;
                end
              end else begin
                oct_q <= oct_q - 7'd1;
              end
            end else begin
              notePre_q <= notePre_q - 9'd1;
            end

            if (tempo_q == '0) begin
              tempo_q <= TEMPO_RELOAD;
              beat_q  <= beat_q - 4'd1;
              if (beat_q == 4'd1) begin
                music_q <= 1'b0;
                if (noteIdx_q == LAST_IDX) begin
                  if (loop_en) begin
                    state_q   <= FETCH;
                    noteIdx_q <= '0;
                    rdData_q  <= mem_q[IDX_ZERO];
                  end else begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    noteIdx_q <= '0;
                  end
                end else begin
                  state_q   <= FETCH;
                  noteIdx_q <= nextIdx;
                  rdData_q  <= mem_q[nextIdx];
                end
              end
            end else begin
              tempo_q <= tempo_q - TEMPO_ONE;
            end
          end

          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            music_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign music_out = music_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign note_idx  = noteIdx_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Self-checking bench for music_sequencer: a timeline model derived from the
// melody rules predicts busy/done/music/note_idx for every cycle of playback.
`timescale 1ns/1ps
module tb_music_sequencer;

  localparam int DEPTH     = 4;
  localparam int ADDR_W    = 2;
  localparam int TEMPO_CYC = 1200;
  localparam int TEMPO_W   = 11;
  localparam int VW        = ADDR_W + 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0]       wr_data;
  logic              music_out;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] note_idx;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [11:0]   image [DEPTH];
  logic [VW-1:0] expQ[$];
  int            togQ[$];
  int            holdCnt [DEPTH];
  int            doneCnt;
  int            firstDoneAt;

  music_sequencer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TEMPO_CYC(TEMPO_CYC), .TEMPO_W(TEMPO_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .music_out(music_out), .busy(busy), .done(done), .note_idx(note_idx)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  function automatic int divOf(input int note);
    int table_[12] = '{512, 483, 456, 431, 406, 384, 362, 342, 323, 304, 287, 271};
    return table_[note];
  endfunction

  function automatic logic [VW-1:0] pack(input bit b, input bit d, input bit m, input int idx);
    logic [ADDR_W-1:0] i;
    i = ADDR_W'(idx);
    return {b, d, m, (b ? i : {ADDR_W{1'b0}})};
  endfunction

  // Expected per-cycle outputs from the cycle after start is sampled
  task automatic build_timeline(input bit loopEn, input int maxLen);
    int idx, dur, note, oct, hp, total;
    bit rest, finished;
    logic [11:0] e;
    expQ.delete();
    idx = 0;
    finished = 0;
    expQ.push_back(pack(1, 0, 0, idx));
    while (!finished && expQ.size() < maxLen) begin
      e    = image[idx];
      dur  = int'(e[3:0]);
      note = int'(e[7:4]);
      oct  = int'(e[10:8]);
      rest = e[11] || (note >= 12);
      if (dur == 0) begin
        if (loopEn && idx != 0) begin
          idx = 0;
          expQ.push_back(pack(1, 0, 0, idx));
        end else begin
          expQ.push_back(pack(0, 1, 0, 0));
          expQ.push_back(pack(0, 0, 0, 0));
          finished = 1;
        end
      end else begin
        hp    = rest ? 1 : divOf(note) * (1 << (7 - oct));
        total = dur * TEMPO_CYC;
        for (int p = 1; p <= total && expQ.size() < maxLen; p++)
          expQ.push_back(pack(1, 0, (!rest) && ((((p - 1) / hp) % 2) == 1), idx));
        if (idx == DEPTH - 1) begin
          if (loopEn) begin
            idx = 0;
            expQ.push_back(pack(1, 0, 0, idx));
          end else begin
            expQ.push_back(pack(0, 1, 0, 0));
            expQ.push_back(pack(0, 0, 0, 0));
            finished = 1;
          end
        end else begin
          idx++;
          expQ.push_back(pack(1, 0, 0, idx));
        end
      end
    end
    while (expQ.size() > maxLen) void'(expQ.pop_back());
  endtask

  task automatic write_image();
    for (int i = 0; i < DEPTH; i++) begin
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(i);
      wr_data = image[i];
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  // Start playback and compare every cycle against the model timeline
  task automatic play_and_check(input string name, input bit loopEn, input int maxLen, input int pulseAt);
    logic [VW-1:0] act;
    logic prevMusic;
    build_timeline(loopEn, maxLen);
    togQ.delete();
    doneCnt = 0;
    firstDoneAt = -1;
    for (int k = 0; k < DEPTH; k++) holdCnt[k] = 0;
    prevMusic = 1'b0;
    start   = 1'b1;
    loop_en = loopEn;
    for (int i = 0; i < expQ.size(); i++) begin
      @(negedge clk);
      start = 1'b0;
      act = {busy, done, music_out, (expQ[i][VW-1] ? note_idx : {ADDR_W{1'b0}})};
      nCompared++;
      if (act !== expQ[i]) begin
        nMismatched++;
        $display("[TB] FAIL %s cycle %0d: busy/done/music/idx got %b expected %b", name, i, act, expQ[i]);
      end
      if (i > 0 && music_out !== prevMusic) togQ.push_back(i);
      prevMusic = music_out;
      if (busy === 1'b1) holdCnt[note_idx]++;
      if (done === 1'b1) begin
        doneCnt++;
        if (firstDoneAt < 0) firstDoneAt = i;
      end
      if (i == pulseAt) start = 1'b1;
    end
  endtask

  task automatic check_stop(input string name);
    logic [VW-1:0] act;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    act = {busy, done, music_out, note_idx};
    nCompared++;
    if (act !== '0) begin
      nMismatched++;
      $display("[TB] FAIL %s: busy/done/music/idx got %b expected all zero", name, act);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    logic [VW-1:0] act;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    act = {busy, done, music_out, note_idx};
    nCompared++;
    if (act !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_initial: got %b expected all zero", act);
    end
    rst = 1'b0;
    image = '{12'h702, 12'h000, 12'h000, 12'h000};
    write_image();
    play_and_check("reset_prelude", 1'b0, 200, -1);
    rst = 1'b1;
    @(negedge clk);
    act = {busy, done, music_out, note_idx};
    nCompared++;
    if (act !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_mid_play: got %b expected all zero", act);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tone();
    image = '{12'h702, 12'h000, 12'h000, 12'h000};
    write_image();
    play_and_check("tone_a7", 1'b0, 100000, -1);
    check_int("tone_a7_halfperiod", (togQ.size() >= 2) ? togQ[1] - togQ[0] : -1, 512);
    check_int("tone_a7_done", doneCnt, 1);
    image[0] = 12'h6B2;
    write_image();
    play_and_check("tone_gs6", 1'b0, 100000, -1);
    check_int("tone_gs6_halfperiod", (togQ.size() >= 2) ? togQ[1] - togQ[0] : -1, 542);
  endtask

  task automatic test_sequencing();
    image = '{12'h702, 12'h801, 12'h731, 12'h000};
    write_image();
    play_and_check("sequence", 1'b0, 100000, -1);
    check_int("seq_hold0", holdCnt[0], 2 * TEMPO_CYC + 1);
    check_int("seq_hold1", holdCnt[1], TEMPO_CYC + 1);
    check_int("seq_hold2", holdCnt[2], TEMPO_CYC + 1);
    check_int("seq_done_count", doneCnt, 1);
  endtask

  task automatic test_loop();
    image = '{12'h702, 12'h801, 12'h731, 12'h000};
    write_image();
    play_and_check("loop", 1'b1, 2 * (4 * TEMPO_CYC + 4) + 50, -1);
    check_int("loop_no_done", doneCnt, 0);
    check_stop("loop_stop");
    image = '{12'h000, 12'h000, 12'h000, 12'h000};
    write_image();
    play_and_check("empty_loop", 1'b1, 10, -1);
    check_int("empty_loop_done_at", firstDoneAt, 1);
    check_int("empty_loop_done_count", doneCnt, 1);
  endtask

  task automatic test_full_ram();
    image = '{12'h751, 12'h751, 12'h751, 12'h751};
    write_image();
    play_and_check("full_ram", 1'b0, 100000, -1);
    for (int k = 0; k < DEPTH; k++) check_int($sformatf("full_ram_hold%0d", k), holdCnt[k], TEMPO_CYC + 1);
    check_int("full_ram_done_count", doneCnt, 1);
  endtask

  task automatic test_stop_priority();
    image = '{12'h702, 12'h801, 12'h731, 12'h000};
    write_image();
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check_int("start_stop_busy", int'(busy), 0);
    @(negedge clk);
    check_int("start_stop_still_idle", int'(busy), 0);
    play_and_check("start_while_busy", 1'b0, 600, 100);
    check_stop("stop_in_play");
    @(negedge clk);
    check_int("stop_stays_idle", int'(busy), 0);
  endtask

  task automatic test_back_to_back();
    image = '{12'h000, 12'h000, 12'h000, 12'h000};
    write_image();
    loop_en = 1'b0;
    start   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_int($sformatf("b2b_busy%0d", i), int'(busy), (i % 2 == 0) ? 1 : 0);
      check_int($sformatf("b2b_done%0d", i), int'(done), (i % 2 == 1) ? 1 : 0);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    int r;
    logic [3:0] dur;
    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < DEPTH; k++) begin
        r   = $urandom_range(0, 5);
        dur = (r == 0) ? 4'd0 : 4'((r % 2) + 1);
        image[k] = {($urandom_range(0, 7) == 0), 3'($urandom_range(4, 7)), 4'($urandom_range(0, 15)), dur};
      end
      write_image();
      play_and_check($sformatf("random%0d", it), 1'($urandom_range(0, 1)), 6000, -1);
      check_stop($sformatf("random%0d_stop", it));
    end
  endtask

  // Scenario sequence
  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    test_reset();
    test_tone();
    test_sequencing();
    test_loop();
    test_full_ram();
    test_stop_priority();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
